serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
Serial frame receiver, the far end of the team's serial transmit path. Recovers frames on a single wire: one start bit (0), DATA_W data bits LSB first, one parity bit, and at least one idle-high bit. It presents the parallel word with parity and framing status as a one-cycle valid pulse. It sits between the pad/line input and the consumer logic.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 1, clk cycles per serial bit (>=1); 1 gives one bit per clock, matching the transmitter
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data bits), 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line; idles high
data_out  output  DATA_W  last received word; held until the next frame completes
data_valid  output  1  one-cycle pulse when data_out/parity_err/frame_err update
parity_err  output  1  parity mismatch on the last frame; valid with data_valid, held after
frame_err  output  1  stop/idle bit sampled low on the last frame; valid with data_valid, held after
busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock clk. Reset is asynchronous and active-low.
- Reset: state=IDLE, 2-flop rx synchronizer = 1/1, counters=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
- Reset mid-frame aborts the frame immediately. No partial word is emitted.
- s = synchronized rx (2-flop delay). All decisions use s only.
- Sample offset H = (CLKS_PER_BIT-1)/2, integer division. clk_cnt is wide enough for CLKS_PER_BIT-1. bit_cnt is wide enough for DATA_W.
- IDLE: if s==0:
  - H==0: go to DATA with clk_cnt=0.
  - H>0: go to START with clk_cnt=1.
- START: if clk_cnt==H:
  - s==0: go to DATA with clk_cnt=0, bit_cnt=0.
  - s==1: false start; go to IDLE, no output.
  - Otherwise clk_cnt++.
- DATA, PARITY and STOP share one timing rule. clk_cnt increments; when clk_cnt==CLKS_PER_BIT-1 the state samples s and sets clk_cnt=0. Each sample therefore lands at offset H of its bit.
- DATA: on each sample, shift s into shift_reg at the MSB, shifting right, so the first bit received ends at bit 0. Increment bit_cnt. After the DATA_W-th sample, go to PARITY.
- PARITY: on sample, compute perr = s ^ (^shift_reg) ^ PARITY_ODD, then go to STOP.
- STOP: on sample, on the next edge:
  - data_out<=shift_reg, parity_err<=perr, frame_err<=~s, data_valid<=1 for exactly one cycle.
  - Next state is IDLE if s==1, else BREAK.
- BREAK: wait until s==1, then go to IDLE. No start detection while in BREAK.
- Latency: let the edge at which rx first shows the start bit be cycle 0. data_valid is high in cycle 3 + (DATA_W+2)*CLKS_PER_BIT + H.
  - Defaults: cycle 13.
  - CLKS_PER_BIT=16, DATA_W=8: cycle 170.
- Back-to-back frames: a start bit immediately following the single idle/stop bit is detected. No idle gap beyond one bit is required.
- Errors do not suppress data: data_out updates even when parity_err or frame_err is 1.
- No overrun handling. The consumer must capture on the data_valid pulse.
- State encoding: IDLE, START, DATA, PARITY, STOP, BREAK. Any illegal encoding returns to IDLE on the next clock.

Test Plan:
- Defaults; drive one frame per clock: start 0, 0xA5 LSB first, parity 0, then rx=1 -> data_valid high in cycle 13 only; data_out=0xA5, parity_err=0, frame_err=0; busy low after the frame.
- Defaults; frame 0x01 with parity bit 0 -> data_out=0x01, parity_err=1, frame_err=0. Repeat with PARITY_ODD=1 and the same bits -> parity_err=0.
- Defaults; frame 0x3C with correct parity, but stop bit 0 and rx held low for 5 more cycles, then high -> frame_err=1, data_out=0x3C. No second data_valid until rx returns high and a new start arrives.
- CLKS_PER_BIT=16; rx low for 4 cycles then high -> no data_valid, busy returns low by cycle 10. Then a full 0x5A frame -> data_valid in cycle 170 (relative to its start), data_out=0x5A.
- Defaults; frames 0x11 then 0xEE, each separated by exactly one idle bit -> two data_valid pulses 11 cycles apart with the correct words, no errors.
- Defaults; assert reset at cycle 6 of a frame for 2 cycles, then send 0x77 -> all outputs 0 during reset, no pulse for the aborted frame, one valid 0x77 afterwards.

Source files
------------

// File: rtl/serial_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop/idle bit.
// Recovers the word from a 2-flop synchronized line and reports parity/framing status
// with a one-cycle data_valid pulse.
`timescale 1ns/1ps

module serial_rx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW   = $clog2(DATA_W + 1);
  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] HALF_C   = CW'(HALF);
  localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          ODD_BIT  = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t            state;
  logic              sync1;
  logic              s;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              perr;
  logic              bit_tick;

  // Sample point of DATA/PARITY/STOP: last count of the current bit period
  assign bit_tick = (clk_cnt == LAST_C);

  // Next shift register value: new bit enters at the MSB, first bit ends at bit 0
  always_comb begin
    shift_next             = shift_reg >> 1;
    shift_next[DATA_W-1]   = s;
  end

  // Synchronizer, frame FSM and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b1;
      s          <= 1'b1;
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1      <= rx;
      s          <= sync1;
      data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!s) begin
            busy    <= 1'b1;
            bit_cnt <= '0;
            if (HALF == 0) begin
              state   <= DATA;
              clk_cnt <= '0;
            end else begin
              state   <= START;
              clk_cnt <= CW'(1);
            end
          end
        end

        START: begin
          if (clk_cnt == HALF_C) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (!s) begin
              state <= DATA;
            end else begin
              // Glitch shorter than half a bit: treat as a false start
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_tick) begin
            clk_cnt   <= '0;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        PARITY: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            perr    <= s ^ (^shift_reg) ^ ODD_BIT;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_tick) begin
            clk_cnt    <= '0;
            data_out   <= shift_reg;
            parity_err <= perr;
            frame_err  <= ~s;
            data_valid <= 1'b1;
            if (s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        BREAK: begin
          // Line held low past the stop bit: wait for idle before hunting a start
          if (s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: three instances (even parity, odd parity,
// 16 clocks per bit) driven one at a time; a per-instance scoreboard holds the
// expected word, status and pulse cycle for every frame sent.
`timescale 1ns/1ps

module tb_serial_rx;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx0, rx1, rx2;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       pe0, pe1, pe2;
  logic       fe0, fe1, fe2;
  logic       b0, b1, b2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  serial_rx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .rx(rx0), .data_out(d0), .data_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .busy(b0));

  serial_rx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .reset(reset), .rx(rx1), .data_out(d1), .data_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1));

  serial_rx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_ODD(0)) u2 (
    .clk(clk), .reset(reset), .rx(rx2), .data_out(d2), .data_valid(v2),
    .parity_err(pe2), .frame_err(fe2), .busy(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int which, input exp_t e);
    case (which)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Hold the line at v for n cycles; returns 1 time unit after a rising edge
  task automatic drive_bit(input int which, input logic v, input int n);
    set_rx(which, v);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input int stop_low);
    int   cpb;
    logic odd;
    exp_t e;
    cpb    = (which == 2) ? 16 : 1;
    odd    = (which == 1);
    e.data = d;
    e.perr = pbit ^ (^d) ^ odd;
    e.ferr = (stop_low > 0);
    e.cyc  = cyc + 3 + 10 * cpb + (cpb - 1) / 2;
    push_exp(which, e);
    drive_bit(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], cpb);
    drive_bit(which, pbit, cpb);
    if (stop_low > 0) drive_bit(which, 1'b0, stop_low);
    drive_bit(which, 1'b1, cpb);
  endtask

  task automatic mon(input int which, input logic dv, input logic [7:0] d,
                     input logic pe, input logic fe);
    exp_t e;
    int   sz;
    if (dv) begin
      case (which)
        0:       sz = q0.size();
        1:       sz = q1.size();
        default: sz = q2.size();
      endcase
      if (sz == 0) begin
        chk($sformatf("dut%0d_unexpected_valid", which), 32'd1, 32'd0);
      end else begin
        case (which)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("dut%0d_data", which), 32'(d), 32'(e.data));
        chk($sformatf("dut%0d_parity_err", which), 32'(pe), 32'(e.perr));
        chk($sformatf("dut%0d_frame_err", which), 32'(fe), 32'(e.ferr));
        chk($sformatf("dut%0d_valid_cycle", which), 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  // Scoreboard consumers: compare every data_valid pulse against the queue head
  always @(negedge clk) begin
    mon(0, v0, d0, pe0, fe0);
    mon(1, v1, d1, pe1, fe1);
    mon(2, v2, d2, pe2, fe2);
  end

  initial begin
    int n;
    int t;
    reset = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", 32'(d0), 32'd0);
    chk("reset_data_valid", 32'(v0), 32'd0);
    chk("reset_parity_err", 32'(pe0), 32'd0);
    chk("reset_frame_err", 32'(fe0), 32'd0);
    chk("reset_busy", 32'(b0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // Clean frame, then check the receiver settles back to idle
    send_frame(0, 8'hA5, 1'b0, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("busy_after_frame", 32'(b0), 32'd0);

    // Same bits into even and odd parity receivers
    send_frame(0, 8'h01, 1'b0, 0);
    send_frame(1, 8'h01, 1'b0, 0);
    repeat (5) begin @(posedge clk); #1; end

    // Stop bit low with an extended break
    send_frame(0, 8'h3C, 1'b0, 6);
    repeat (8) begin @(posedge clk); #1; end

    // 16x oversampled: false start, then a real frame
    n = cyc;
    drive_bit(2, 1'b0, 4);
    set_rx(2, 1'b1);
    @(negedge clk);
    chk("busy_during_false_start", 32'(b2), 32'd1);
    while (cyc < n + 10) @(posedge clk);
    @(negedge clk);
    chk("busy_after_false_start", 32'(b2), 32'd0);
    @(posedge clk);
    #1;
    repeat (4) begin @(posedge clk); #1; end
    send_frame(2, 8'h5A, 1'b0, 0);
    repeat (30) begin @(posedge clk); #1; end

    // Back-to-back frames with one idle bit between them
    send_frame(0, 8'h11, 1'b0, 0);
    send_frame(0, 8'hEE, 1'b0, 0);
    repeat (6) begin @(posedge clk); #1; end

    // Reset in the middle of a frame aborts it
    drive_bit(0, 1'b0, 1);
    for (int i = 0; i < 5; i++) drive_bit(0, 1'(i % 2), 1);
    chk("busy_before_abort", 32'(b0), 32'd1);
    reset = 1'b0;
    set_rx(0, 1'b1);
    #1;
    chk("abort_data_out", 32'(d0), 32'd0);
    chk("abort_busy", 32'(b0), 32'd0);
    @(negedge clk);
    chk("abort_data_valid", 32'(v0), 32'd0);
    chk("abort_parity_err", 32'(pe0), 32'd0);
    chk("abort_frame_err", 32'(fe0), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    send_frame(0, 8'h77, 1'b0, 0);

    // Wait, bounded, for every expected pulse to be seen
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (20) @(posedge clk);
    chk("pending_expected_frames", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
